// File: rtl/logic_ram_rmw_pkg.sv
// Shared types for the logic RAM read-modify-write front end.
package logic_ram_rmw_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ADD   = 2'd2,
    OP_OR    = 2'd3
  } rmw_op_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_ram_rmw_alu.sv
// Combinational op unit: computes the post-op word and whether it must be written back.
module logic_ram_rmw_alu
  import logic_ram_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            opcode_in,
  input  logic [DATA_WIDTH-1:0] old_in,
  input  logic [DATA_WIDTH-1:0] operand_in,
  output logic [DATA_WIDTH-1:0] new_out,
  output logic                  wr_out
);

  always_comb begin
    new_out = old_in;
    wr_out  = 1'b0;
    case (rmw_op_t'(opcode_in))
      OP_READ:  wr_out = 1'b0;
      OP_WRITE: begin
        new_out = operand_in;
        wr_out  = 1'b1;
      end
      OP_ADD: begin
        new_out = old_in + operand_in;
        wr_out  = 1'b1;
      end
      OP_OR: begin
        new_out = old_in | operand_in;
        wr_out  = 1'b1;
      end
      default: wr_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_ram_rmw_stage.sv
// RMW front end: init sweep after reset, then one atomic op per cycle with
// one-deep write forwarding to cover the RAM's read-old-on-collision behaviour.
module logic_ram_rmw_stage
  import logic_ram_rmw_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  DEPTH      = 217,
  parameter int                  ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_opcode,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_operand,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr_out,
  input  logic [DATA_WIDTH-1:0] ram_rddata_in,
  output logic                  ram_wren_out,
  output logic [ADDR_WIDTH-1:0] ram_wraddr_out,
  output logic [DATA_WIDTH-1:0] ram_wrdata_out
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    vld_p1_q, vld_p1_d;
  logic [1:0]              op_p1_q, op_p1_d;
  logic [ADDR_WIDTH-1:0]   addr_p1_q, addr_p1_d;
  logic [DATA_WIDTH-1:0]   operand_p1_q, operand_p1_d;
  logic                    fwd_vld_q, fwd_vld_d;
  logic [ADDR_WIDTH-1:0]   fwd_addr_q, fwd_addr_d;
  logic [DATA_WIDTH-1:0]   fwd_data_q, fwd_data_d;

  logic                    accept;
  logic                    fwd_hit;
  logic [DATA_WIDTH-1:0]   old_p1;
  logic [DATA_WIDTH-1:0]   alu_new;
  logic                    alu_wr;
  logic                    wr_p1;
  logic                    init_wr;

  // Stage 0: accept and register the op; the RAM read is launched in parallel.
  assign in_ready       = !rst && (state_q == ST_RUN);
  assign accept         = in_valid && in_ready;
  assign ram_rdaddr_out = in_addr;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vld_p1_d     = accept;
    op_p1_d      = in_opcode;
    addr_p1_d    = in_addr;
    operand_p1_d = in_operand;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) state_d = ST_RUN;
    end
    if (rst) begin
      state_d  = ST_INIT;
      cnt_d    = '0;
      vld_p1_d = 1'b0;
    end
  end

  // Stage 1: resolve the pre-op value, compute the new word, write back.
  assign fwd_hit = fwd_vld_q && (fwd_addr_q == addr_p1_q);
  assign old_p1  = fwd_hit ? fwd_data_q : ram_rddata_in;

  logic_ram_rmw_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .opcode_in (op_p1_q),
    .old_in    (old_p1),
    .operand_in(operand_p1_q),
    .new_out   (alu_new),
    .wr_out    (alu_wr)
  );

  // Reset is gated in combinationally so an in-flight op can neither report nor commit.
  assign wr_p1     = !rst && vld_p1_q && alu_wr;
  assign init_wr   = !rst && (state_q == ST_INIT);
  assign out_valid = !rst && vld_p1_q;
  assign out_data  = old_p1;

  assign ram_wren_out   = init_wr || wr_p1;
  assign ram_wraddr_out = init_wr ? cnt_q : addr_p1_q;
  assign ram_wrdata_out = init_wr ? INIT_VALUE : alu_new;

  always_comb begin
    fwd_vld_d  = wr_p1;
    fwd_addr_d = addr_p1_q;
    fwd_data_d = alu_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      vld_p1_q  <= 1'b0;
      fwd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_p1_q  <= vld_p1_d;
      fwd_vld_q <= fwd_vld_d;
    end
    op_p1_q      <= op_p1_d;
    addr_p1_q    <= addr_p1_d;
    operand_p1_q <= operand_p1_d;
    fwd_addr_q   <= fwd_addr_d;
    fwd_data_q   <= fwd_data_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      assert ({1'b0, in_addr} < (ADDR_WIDTH + 1)'(DEPTH))
        else $error("logic_ram_rmw_stage: in_addr %0d out of range", in_addr);
    end
  end

endmodule
